// File: rtl/bp_port_sched.sv
// bp_port_sched: port sequencer for the single-ported branch history table.
//   After reset it sweeps every table entry to INIT_VAL, one write per cycle.
//   In RUN it grants the table port each cycle to either a pending write-back
//   (priority) or a prediction lookup. Looked-up branches are kept in an
//   in-order FIFO so a resolution only has to carry the actual outcome.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   lookup_valid_i/idx_i/ready_o  lookup request (low IDX_W bits of idx_i)
//   pred_valid_o, prediction_o    prediction, one cycle after lookup accept
//   resolve_valid_i/br_result_i   outcome of the oldest in-flight branch
//   resolve_ready_o               resolution accepted when valid & ready
//   mispredict_o                  pulse the cycle after a wrong prediction resolves
//   tbl_en/we/addr/wdata_o        table port, tbl_rdata_i has 1-cycle latency
//   init_done_o                   high once the init sweep is complete
//   inflight_o                    number of queued (pushed) branches
module bp_port_sched #(
    parameter int IDX_W    = 10,
    parameter int CTR_W    = 2,
    parameter int DEPTH    = 8,
    parameter int INIT_VAL = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       lookup_valid_i,
    input  logic [31:0]                idx_i,
    output logic                       lookup_ready_o,
    output logic                       pred_valid_o,
    output logic                       prediction_o,
    input  logic                       resolve_valid_i,
    input  logic                       br_result_i,
    output logic                       resolve_ready_o,
    output logic                       mispredict_o,
    output logic                       tbl_en_o,
    output logic                       tbl_we_o,
    output logic [IDX_W-1:0]           tbl_addr_o,
    output logic [CTR_W-1:0]           tbl_wdata_o,
    input  logic [CTR_W-1:0]           tbl_rdata_i,
    output logic                       init_done_o,
    output logic [$clog2(DEPTH):0]     inflight_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CTR_W-1:0] INIT_CTR = CTR_W'(INIT_VAL);
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    state_t state_q, state_d;

    logic [IDX_W-1:0] init_addr_q;
    logic             lk_vld_q;
    logic [IDX_W-1:0] lk_idx_q;
    logic             wb_vld_q;
    logic [IDX_W-1:0] wb_idx_q;
    logic [CTR_W-1:0] wb_ctr_q;
    logic             mispredict_q;

    logic [IDX_W-1:0] fifo_idx_q [DEPTH];
    logic [CTR_W-1:0] fifo_ctr_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] cnt_q;

    logic             run, lk_acc, rs_acc;
    logic [CTR_W-1:0] captured, head_ctr, new_ctr;

    if (IDX_W < 32) begin : g_unused
        logic unused_idx_bits;
        assign unused_idx_bits = ^idx_i[31:IDX_W];
    end

    assign run = (state_q == ST_RUN);

    // The pending (accepted, not yet pushed) lookup is counted as well, so a
    // lookup in the cycle before the push lands can never overfill the FIFO.
    assign lookup_ready_o  = run && !wb_vld_q &&
                             ((cnt_q + CNT_W'(lk_vld_q)) < CNT_W'(DEPTH));
    assign resolve_ready_o = run && (cnt_q != '0) && !wb_vld_q;
    assign lk_acc = lookup_valid_i && lookup_ready_o;
    assign rs_acc = resolve_valid_i && resolve_ready_o;

    // A write-back issuing in the read's data cycle is newer than the array
    // contents returned on tbl_rdata_i.
    assign captured = (wb_vld_q && run && (wb_idx_q == lk_idx_q)) ? wb_ctr_q : tbl_rdata_i;

    assign head_ctr = fifo_ctr_q[rd_ptr_q];
    always_comb begin
        new_ctr = head_ctr;
        if (br_result_i) begin
            if (head_ctr != CTR_MAX) new_ctr = head_ctr + 1'b1;
        end else begin
            if (head_ctr != '0) new_ctr = head_ctr - 1'b1;
        end
    end

    assign pred_valid_o = lk_vld_q;
    assign prediction_o = lk_vld_q & captured[CTR_W-1];
    assign mispredict_o = mispredict_q;
    assign init_done_o  = run;
    assign inflight_o   = cnt_q;

    // Next state and table port mux.
    always_comb begin
        state_d     = state_q;
        tbl_en_o    = 1'b0;
        tbl_we_o    = 1'b0;
        tbl_addr_o  = '0;
        tbl_wdata_o = '0;
        case (state_q)
            ST_INIT: begin
                tbl_en_o    = 1'b1;
                tbl_we_o    = 1'b1;
                tbl_addr_o  = init_addr_q;
                tbl_wdata_o = INIT_CTR;
                if (init_addr_q == {IDX_W{1'b1}}) state_d = ST_RUN;
            end
            default: begin
                if (wb_vld_q) begin
                    tbl_en_o    = 1'b1;
                    tbl_we_o    = 1'b1;
                    tbl_addr_o  = wb_idx_q;
                    tbl_wdata_o = wb_ctr_q;
                end else if (lk_acc) begin
                    tbl_en_o   = 1'b1;
                    tbl_addr_o = idx_i[IDX_W-1:0];
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_INIT;
            init_addr_q  <= '0;
            lk_vld_q     <= 1'b0;
            lk_idx_q     <= '0;
            wb_vld_q     <= 1'b0;
            wb_idx_q     <= '0;
            wb_ctr_q     <= '0;
            mispredict_q <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) init_addr_q <= init_addr_q + 1'b1;

            lk_vld_q <= lk_acc;
            if (lk_acc) lk_idx_q <= idx_i[IDX_W-1:0];

            // rs_acc needs an empty write-back register, so load and issue
            // never coincide.
            if (rs_acc) begin
                wb_vld_q <= 1'b1;
                wb_idx_q <= fifo_idx_q[rd_ptr_q];
                wb_ctr_q <= new_ctr;
            end else if (wb_vld_q) begin
                wb_vld_q <= 1'b0;
            end

            mispredict_q <= rs_acc && (br_result_i != head_ctr[CTR_W-1]);

            if (lk_vld_q) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rs_acc)   rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + CNT_W'(lk_vld_q) - CNT_W'(rs_acc);
        end
    end

    // FIFO payload: no reset needed, occupancy is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (wb_vld_q && run) begin
            for (int i = 0; i < DEPTH; i++)
                if (fifo_idx_q[i] == wb_idx_q) fifo_ctr_q[i] <= wb_ctr_q;
        end
        if (lk_vld_q && !rst_i) begin
            fifo_idx_q[wr_ptr_q] <= lk_idx_q;
            fifo_ctr_q[wr_ptr_q] <= captured;
        end
    end
endmodule

// File: tb/tb_bp_port_sched.sv
module tb_bp_port_sched;
    localparam int IDX_W = 4;
    localparam int CTR_W = 2;
    localparam int DEPTH = 8;

    logic             clk_i = 0;
    logic             rst_i = 1;
    logic             lookup_valid_i = 0;
    logic [31:0]      idx_i = '0;
    logic             lookup_ready_o;
    logic             pred_valid_o, prediction_o;
    logic             resolve_valid_i = 0, br_result_i = 0;
    logic             resolve_ready_o, mispredict_o;
    logic             tbl_en_o, tbl_we_o;
    logic [IDX_W-1:0] tbl_addr_o;
    logic [CTR_W-1:0] tbl_wdata_o;
    logic [CTR_W-1:0] tbl_rdata_i;
    logic             init_done_o;
    logic [3:0]       inflight_o;

    bp_port_sched #(.IDX_W(IDX_W), .CTR_W(CTR_W), .DEPTH(DEPTH), .INIT_VAL(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .lookup_valid_i(lookup_valid_i), .idx_i(idx_i), .lookup_ready_o(lookup_ready_o),
        .pred_valid_o(pred_valid_o), .prediction_o(prediction_o),
        .resolve_valid_i(resolve_valid_i), .br_result_i(br_result_i),
        .resolve_ready_o(resolve_ready_o), .mispredict_o(mispredict_o),
        .tbl_en_o(tbl_en_o), .tbl_we_o(tbl_we_o), .tbl_addr_o(tbl_addr_o),
        .tbl_wdata_o(tbl_wdata_o), .tbl_rdata_i(tbl_rdata_i),
        .init_done_o(init_done_o), .inflight_o(inflight_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural table memory with 1-cycle read latency.
    logic [CTR_W-1:0] mem [2**IDX_W];
    always @(posedge clk_i) begin
        if (tbl_en_o && tbl_we_o) mem[tbl_addr_o] <= tbl_wdata_o;
        if (tbl_en_o && !tbl_we_o) tbl_rdata_i <= mem[tbl_addr_o];
    end

    int n_tests = 0;
    int n_fail  = 0;

    int exp_wr_q [$];    // {addr, data} packed as addr*16+data
    int exp_pred_q [$];
    int exp_misp_q [$];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compares every table write, prediction and post-resolution
    // mispredict flag against the scoreboard queues.
    logic res_prev = 0;
    always @(negedge clk_i) begin
        if (rst_i) begin
            res_prev = 0;
        end else begin
            if (res_prev) begin
                if (exp_misp_q.size() == 0) chk("misp_unexpected_resolve", 1, 0);
                else chk("mispredict", int'(mispredict_o), exp_misp_q.pop_front());
            end else if (mispredict_o) begin
                chk("misp_spurious", 1, 0);
            end
            res_prev = resolve_valid_i && resolve_ready_o;
            if (tbl_en_o && tbl_we_o) begin
                if (exp_wr_q.size() == 0) chk("write_unexpected", int'(tbl_addr_o)*16 + int'(tbl_wdata_o), -1);
                else chk("write_addr*16+data", int'(tbl_addr_o)*16 + int'(tbl_wdata_o), exp_wr_q.pop_front());
            end
            if (pred_valid_o) begin
                if (exp_pred_q.size() == 0) chk("pred_unexpected", int'(prediction_o), -1);
                else chk("prediction", int'(prediction_o), exp_pred_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk_i); #1;
    endtask

    task automatic do_lookup(input int idx, input int exp_pred);
        bit ok = 0;
        exp_pred_q.push_back(exp_pred);
        lookup_valid_i = 1;
        idx_i = 32'(idx);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_i);
            if (lookup_ready_o) begin ok = 1; break; end
        end
        if (!ok) chk("lookup_timeout", 0, 1);
        step();
        lookup_valid_i = 0;
    endtask

    task automatic do_resolve(input int br, input int wr_addr, input int wr_data, input int misp);
        bit ok = 0;
        exp_wr_q.push_back(wr_addr*16 + wr_data);
        exp_misp_q.push_back(misp);
        resolve_valid_i = 1;
        br_result_i = br[0];
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_i);
            if (resolve_ready_o) begin ok = 1; break; end
        end
        if (!ok) chk("resolve_timeout", 0, 1);
        step();
        resolve_valid_i = 0;
    endtask

    task automatic init_sweep();
        for (int a = 0; a < 16; a++) exp_wr_q.push_back(a*16 + 1);
        rst_i = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk_i);
            chk("init_ready_low", int'(lookup_ready_o | resolve_ready_o | init_done_o), 0);
        end
        @(negedge clk_i);
        chk("init_done", int'(init_done_o), 1);
        step();
    endtask

    // {pred, br, wdata, misp} for lookup+resolve pairs on idx 3
    int sat_tbl [8][4] = '{
        '{0,1,2,1}, '{1,1,3,0}, '{1,1,3,0}, '{1,1,3,0},
        '{1,0,2,1}, '{1,0,1,1}, '{0,0,0,0}, '{0,0,0,0}};

    initial begin
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_init_done", int'(init_done_o), 0);
        chk("rst_ready", int'(lookup_ready_o | resolve_ready_o), 0);
        chk("rst_pred_misp", int'(pred_valid_o | mispredict_o), 0);
        chk("rst_inflight", int'(inflight_o), 0);
        step();
        init_sweep();

        // basic lookup/resolve on idx 5
        do_lookup(5, 0);
        do_resolve(1, 5, 2, 1);
        do_lookup(5, 1);
        do_resolve(0, 5, 1, 1);

        // saturation on idx 3
        for (int i = 0; i < 8; i++) begin
            do_lookup(3, sat_tbl[i][0]);
            do_resolve(sat_tbl[i][1], 3, sat_tbl[i][2], sat_tbl[i][3]);
        end

        // full FIFO
        for (int i = 0; i < 8; i++) do_lookup(8 + i, 0);
        repeat (2) @(negedge clk_i);
        chk("full_inflight", int'(inflight_o), 8);
        chk("full_lookup_ready", int'(lookup_ready_o), 0);
        step();
        for (int i = 0; i < 8; i++) do_resolve(0, 8 + i, 0, 0);
        repeat (2) @(negedge clk_i);
        chk("empty_inflight", int'(inflight_o), 0);
        step();
        resolve_valid_i = 1;
        br_result_i = 1;
        repeat (3) begin
            @(negedge clk_i);
            chk("empty_resolve_ready", int'(resolve_ready_o), 0);
        end
        step();
        resolve_valid_i = 0;

        // write-bypass into the FIFO, idx 7 twice
        do_lookup(7, 0);
        do_lookup(7, 0);
        do_resolve(1, 7, 2, 1);
        do_resolve(1, 7, 3, 0);
        repeat (3) step();

        // mid-operation reset with 3 in flight
        do_lookup(1, 0);
        do_lookup(2, 0);
        do_lookup(3, 0);
        repeat (2) @(negedge clk_i);
        chk("pre_rst_inflight", int'(inflight_o), 3);
        step();
        rst_i = 1;
        step();
        @(negedge clk_i);
        chk("midrst_inflight", int'(inflight_o), 0);
        chk("midrst_init_done", int'(init_done_o), 0);
        step();
        init_sweep();
        repeat (3) step();

        chk("wr_queue_drained", exp_wr_q.size(), 0);
        chk("pred_queue_drained", exp_pred_q.size(), 0);
        chk("misp_queue_drained", exp_misp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bp_port_sched.md
Name: bp_port_sched

Overview:
- Sequences the single-ported branch history table (BHT) of the branch predictor.
- Sweeps the table to a known counter value after reset.
- Arbitrates each cycle between a prediction lookup (read) and a resolution update (write).
- Tracks in-flight predictions in order, so that resolutions carry only the branch outcome. Sits between fetch/execute and the BHT storage array.

Parameters:
IDX_W, 10, table index width; table holds 2**IDX_W counters; lookup index is idx_i[IDX_W-1:0].
CTR_W, 2, saturating counter width; prediction is the counter MSB.
DEPTH, 8, maximum in-flight (looked-up, unresolved) branches; power of two, >=2.
INIT_VAL, 1, counter value written to every entry during init (weakly not-taken).

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous active-high reset
lookup_valid_i  in  1  lookup request
idx_i  in  32  branch index; low IDX_W bits used
lookup_ready_o  out  1  lookup accepted when valid&ready
pred_valid_o  out  1  prediction valid, one cycle after accept
prediction_o  out  1  predicted direction (1 = taken)
resolve_valid_i  in  1  oldest in-flight branch resolved
br_result_i  in  1  actual direction of oldest in-flight branch
resolve_ready_o  out  1  resolution accepted when valid&ready
mispredict_o  out  1  one-cycle pulse: accepted resolution disagreed with its prediction
tbl_en_o  out  1  table port enable
tbl_we_o  out  1  table write enable
tbl_addr_o  out  IDX_W  table address
tbl_wdata_o  out  CTR_W  table write data
tbl_rdata_i  in  CTR_W  table read data; valid the cycle after a read (1-cycle latency)
init_done_o  out  1  high once init sweep complete
inflight_o  out  $clog2(DEPTH)+1  in-flight entry count

Behaviour:
- Reset: while rst_i is high, state goes to INIT, init address to 0, FIFO and write-back register cleared. All outputs are 0 except tbl_* during INIT. Reset mid-operation discards every in-flight entry; no table write issues after reset.
- INIT state:
  - One write per cycle: tbl_en_o=1, tbl_we_o=1, tbl_addr_o=addr, tbl_wdata_o=INIT_VAL, for addr 0..2**IDX_W-1.
  - After the write to the last address, go to RUN; init_done_o=1 from the next cycle on.
  - lookup_ready_o and resolve_ready_o are 0 throughout INIT.
- RUN, port arbitration (one access per cycle):
  - If the write-back register is valid: issue the write (en=1, we=1) and clear the register; lookup_ready_o=0.
  - Else lookup_ready_o = (inflight < DEPTH). On accept: en=1, we=0, addr=idx_i[IDX_W-1:0].
  - No access: en=0, we=0.
- Lookup pipeline, accepted at cycle T:
  - At T+1: pred_valid_o=1 and prediction_o = MSB of captured counter.
  - At T+1: push {idx, counter} into FIFO; inflight increments at the T+1 edge.
  - Captured counter is tbl_rdata_i, except when a write in cycle T+1 targets the same index; then it is the write data.
- resolve_ready_o = RUN and FIFO non-empty (pushed entries only) and write-back register empty. Maximum one resolution every 2 cycles.
- On resolve accept:
  - Pop the FIFO head.
  - New counter = ctr+1 saturating at 2**CTR_W-1 if br_result_i=1; ctr-1 saturating at 0 if 0.
  - Load the write-back register with {idx, new}.
  - mispredict_o=1 next cycle iff br_result_i != head counter MSB.
- Write-bypass: when the write-back register issues, every FIFO entry with a matching idx has its counter replaced by the written value, so later resolutions build on the latest state.
- Simultaneous push and pop in one cycle: inflight unchanged. FIFO pointers wrap modulo DEPTH.
- Full FIFO (inflight=DEPTH): lookup_ready_o=0. Empty FIFO: resolve_ready_o=0.
- resolve_valid_i with ready low is ignored; the requester must hold.

Test Plan:
- Init sweep, IDX_W=4: deassert reset -> 16 consecutive writes of 1 to addresses 0..15, then init_done_o=1. Ready outputs are 0 for those 16 cycles.
- Lookup and resolve:
  - Lookup idx 5 -> next cycle pred_valid_o=1, prediction_o=0.
  - Resolve taken -> write addr 5 data 2; mispredict_o=1.
  - Re-lookup idx 5 -> prediction_o=1.
- Saturation: 4 taken resolutions on idx 3 -> writes 2,3,3,3. Then 4 not-taken -> writes 2,1,0,0.
- Full/empty: 8 back-to-back lookups -> inflight_o=8, lookup_ready_o=0. resolve_ready_o=0 whenever inflight_o=0.
- Bypass, two in-flight on idx 7 (ctr 1):
  - First resolution taken -> writes 2.
  - Second resolution taken -> writes 3, not 2.
- Mid-operation reset with 3 in-flight -> inflight_o=0, no write issued, INIT sweep restarts at address 0.
